// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, monitor state encoding and output widths.
package vga_timing_pkg;

    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;

    localparam int COL_W = 10;
    localparam int ROW_W = 9;
    localparam int LIT_W = 19;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } mon_state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Samples a sync line on pix_en and flags the assertion edge in the same pix_en cycle.
// Latency: combinational pulse from the sample; no backpressure, driven purely by pix_en.
module sync_edge_detect #(
    parameter logic SYNC_POL = 1'b0
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic pix_en,
    input  logic sync_in,
    output logic assert_edge
);

    logic prev_q;

    // Reset to the idle level so a stream starting inside a sync pulse is seen as an edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            prev_q <= ~SYNC_POL;
        end else if (pix_en) begin
            prev_q <= sync_in;
        end
    end

    assign assert_edge = pix_en && (sync_in == SYNC_POL) && (prev_q != SYNC_POL);

endmodule

// File: rtl/vga_frame_monitor.sv
// Recovers de/col/row from hs/vs, checks line/frame length, tracks lock and counts lit pixels.
// Latency: de/col/row/pix_rgb one pix_en after the sample; no backpressure, pix_en-paced.
module vga_frame_monitor
    import vga_timing_pkg::*;
#(
    parameter int   H_TOTAL     = DEF_H_TOTAL,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   V_TOTAL     = DEF_V_TOTAL,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             pix_en,
    input  logic             hs,
    input  logic             vs,
    input  logic [3:0]       r,
    input  logic [3:0]       g,
    input  logic [3:0]       b,
    input  logic             clr_err,
    output logic             locked,
    output logic             de,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [11:0]      pix_rgb,
    output logic             frame_done,
    output logic [LIT_W-1:0] lit_count,
    output logic [15:0]      frame_count,
    output logic             err_hline,
    output logic             err_vframe
);

    localparam logic [9:0]  H_LO    = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_HI    = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_LO    = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_HI    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
    localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
    localparam logic [3:0]  LOCK_C  = 4'(LOCK_FRAMES);

    logic             hs_edge, vs_edge;
    mon_state_t       state;
    logic [9:0]       hcnt, vcnt, h_nxt, v_nxt;
    logic             h_armed, v_armed, frame_bad;
    logic [3:0]       clean_cnt, clean_nxt;
    logic [LIT_W-1:0] lit_acc;
    logic             h_mis, v_mis, in_win, de_nxt;
    logic [11:0]      rgb;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .pix_en      (pix_en),
        .sync_in     (hs),
        .assert_edge (hs_edge)
    );

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .pix_en      (pix_en),
        .sync_in     (vs),
        .assert_edge (vs_edge)
    );

    // Position of the current sample: the edge sample itself is column/line 0.
    assign h_nxt     = hs_edge ? 10'd0 : sat_inc10(hcnt);
    assign v_nxt     = vs_edge ? 10'd0 : (hs_edge ? sat_inc10(vcnt) : vcnt);
    assign h_mis     = hs_edge && h_armed && (({1'b0, hcnt} + 11'd1) != H_LEN);
    assign v_mis     = vs_edge && v_armed && (({1'b0, vcnt} + 11'd1) != V_LEN);
    assign in_win    = (h_nxt >= H_LO) && (h_nxt <= H_HI) && (v_nxt >= V_LO) && (v_nxt <= V_HI);
    assign de_nxt    = locked && in_win;
    assign rgb       = {r, g, b};
    assign clean_nxt = clean_cnt + 4'd1;

    always_ff @(posedge CLK) begin
        frame_done <= 1'b0;
        if (!RESET_N) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            de          <= 1'b0;
            col         <= '0;
            row         <= '0;
            pix_rgb     <= '0;
            lit_count   <= '0;
            frame_count <= '0;
            err_hline   <= 1'b0;
            err_vframe  <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            h_armed     <= 1'b0;
            v_armed     <= 1'b0;
            frame_bad   <= 1'b0;
            clean_cnt   <= '0;
            lit_acc     <= '0;
        end else if (pix_en) begin
            hcnt    <= h_nxt;
            vcnt    <= v_nxt;
            de      <= de_nxt;
            col     <= de_nxt ? COL_W'(h_nxt - H_LO) : '0;
            row     <= de_nxt ? ROW_W'(v_nxt - V_LO) : '0;
            pix_rgb <= de_nxt ? rgb : '0;

            if (hs_edge) h_armed <= 1'b1;
            if (vs_edge) v_armed <= 1'b1;

            err_hline  <= h_mis | (err_hline & ~clr_err);
            err_vframe <= v_mis | (err_vframe & ~clr_err);

            if (vs_edge) begin
                frame_done <= 1'b1;
                lit_count  <= locked ? lit_acc : '0;
                lit_acc    <= '0;
                frame_bad  <= 1'b0;
                if (locked && !v_mis) frame_count <= frame_count + 16'd1;
            end else begin
                if (de_nxt && (rgb != 12'h000)) lit_acc <= lit_acc + 1'b1;
                if (h_mis) frame_bad <= 1'b1;
            end

            // Placed last so a drop to SEARCH overrides the arming above.
            case (state)
                SEARCH: begin
                    if (vs_edge) begin
                        state     <= ACQUIRE;
                        clean_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    if (h_mis || v_mis) begin
                        clean_cnt <= '0;
                    end else if (vs_edge && !frame_bad) begin
                        clean_cnt <= clean_nxt;
                        if (clean_nxt >= LOCK_C) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (h_mis || v_mis) begin
                        state   <= SEARCH;
                        locked  <= 1'b0;
                        h_armed <= 1'b0;
                        v_armed <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Receive-side counterpart of the VGA timing generator. It consumes the hs/vs/r/g/b stream the display path drives and recovers pixel coordinates, data-enable and per-frame statistics from the sync edges alone.
- Instantiated beside the Vga block for on-board self-check and in benches as the display model.
- Checks line and frame timing against 640x480@60 parameters, tracks lock, and reports the lit-pixel count per frame. Collision and visibility checks of sprites use that count.

Parameters:
H_TOTAL, 800, pixels per line including blanking
H_SYNC, 96, hs pulse width in pixels
H_BP, 48, back porch after hs pulse, before first active pixel
H_ACTIVE, 640, active pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vs pulse width in lines
V_BP, 33, back porch lines before first active line
V_ACTIVE, 480, active lines per frame
SYNC_POL, 0, asserted level of hs/vs (0 = active-low)
LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
CLK  in  1  system clock
RESET_N  in  1  synchronous active-low reset
pix_en  in  1  one-CLK strobe per pixel; all sampling is qualified by it
hs  in  1  horizontal sync from display path
vs  in  1  vertical sync from display path
r  in  4  red
g  in  4  green
b  in  4  blue
clr_err  in  1  clears sticky error flags
locked  out  1  timing lock achieved
de  out  1  recovered data-enable
col  out  10  recovered column, 0..H_ACTIVE-1, valid when de
row  out  9  recovered row, 0..V_ACTIVE-1, valid when de
pix_rgb  out  12  {r,g,b} aligned with de/col/row
frame_done  out  1  one-CLK pulse at each vs assertion edge
lit_count  out  19  non-black active pixels in the last completed frame
frame_count  out  16  completed frames while locked; wraps
err_hline  out  1  sticky: measured line length != H_TOTAL
err_vframe  out  1  sticky: measured frame length != V_TOTAL lines

Behaviour:
- Reset (RESET_N=0 at CLK edge): every output is 0, all counters are 0, FSM goes to SEARCH. Reset mid-frame discards partial statistics.
- Nothing updates on cycles with pix_en=0. Outputs hold.
- Edge detect: hs/vs are registered on pix_en. An assertion edge is a previous deasserted sample followed by a current asserted sample, per SYNC_POL.
- hcnt (10b): set to 0 on hs assertion edge, else increments and saturates at 1023.
  - At each hs edge, the line length (hcnt+1) is compared with H_TOTAL. A mismatch sets err_hline.
  - The first edge after reset or SEARCH is not checked.
- vcnt (10b): increments on hs edge and saturates. It is set to 0 on a vs assertion edge.
  - At a vs edge, the frame length (vcnt+1) is compared with V_TOTAL. A mismatch sets err_vframe.
  - When vs and hs edges fall on the same sample, vs takes priority for vcnt.
- FSM:
  - SEARCH: wait for the first vs edge, then go to ACQUIRE with clean_cnt=0.
  - ACQUIRE: at each vs edge, if no h/v mismatch occurred during the frame, clean_cnt++. When clean_cnt reaches LOCK_FRAMES, go to LOCKED. Any mismatch resets clean_cnt to 0.
  - LOCKED: any h or v mismatch returns to SEARCH and drops locked on the same registered update.
- Active window:
  - hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - col = hcnt-(H_SYNC+H_BP), row = vcnt-(V_SYNC+V_BP).
  - de = locked AND in window.
  - col, row, de and pix_rgb are registered: latency is one pix_en after the sample. Outside de, col/row/pix_rgb are 0.
- lit accumulator (19b): increments when de and rgb != 0.
  - At a vs edge it is copied into lit_count and cleared. frame_done pulses for exactly one CLK.
  - If not locked, lit_count is loaded with 0.
- frame_count increments at a vs edge only while locked, and wraps 0xFFFF->0.
- Sticky errors are cleared by clr_err. If clr_err and a new error occur in the same cycle, the error wins (flag stays 1).
- Errors are raised in all FSM states except on the unchecked first edge.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480 constants (H_*/V_* defaults).
  - the state enum {SEARCH, ACQUIRE, LOCKED}.
  - width constants COL_W=10, ROW_W=9, LIT_W=19.
- One sub-module, sync_edge_detect, instantiated for hs and vs: pix_en-qualified register plus polarity-aware assertion-edge pulse.

Test Plan:
- Ideal 640x480 stream, pix_en every 4th CLK, SYNC_POL=0, all pixels black → locked=1 after the 2nd clean vs edge; lit_count=0; no errors.
- Locked stream with a white 10x10 block at col 100..109, row 50..59 → at next frame_done lit_count=100; de high with col=100,row=50 one pix_en after that pixel is driven.
- One line shortened to 799 pixels → err_hline=1 sticky, locked drops, FSM in SEARCH; relock after 2 clean frames; clr_err then returns err_hline to 0.
- Frame of 524 lines → err_vframe=1, frame_count stops incrementing until relock.
- RESET_N=0 for one CLK mid-active-line → all outputs 0 next cycle, lit accumulator discarded; first post-reset frame is not error-checked.
- clr_err asserted on the same cycle as an hs length mismatch → err_hline remains 1.
